// File: rtl/pulsegen_seq_if.sv
// Control/status bundle between a sequencer master and pulsegen_seq.
// The run-length input is named repeat_n because "repeat" is a reserved word.
interface pulsegen_seq_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
);
    logic                 start;
    logic                 stop;
    logic [WIDTH-1:0]     period;
    logic [WIDTH-1:0]     repeat_n;
    logic                 ext_trig_en;
    logic                 ext_trig;
    logic [NCH-1:0]       ch_en;
    logic [NCH*WIDTH-1:0] cfg_delay;
    logic [NCH*WIDTH-1:0] cfg_pulse;
    logic [NCH-1:0]       ch_trig;
    logic [NCH*WIDTH-1:0] ch_tdelay;
    logic [NCH*WIDTH-1:0] ch_tpulse;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     fire_cnt;

    modport master (
        output start, stop, period, repeat_n, ext_trig_en, ext_trig,
               ch_en, cfg_delay, cfg_pulse,
        input  ch_trig, ch_tdelay, ch_tpulse, busy, done, fire_cnt
    );

    modport slave (
        input  start, stop, period, repeat_n, ext_trig_en, ext_trig,
               ch_en, cfg_delay, cfg_pulse,
        output ch_trig, ch_tdelay, ch_tpulse, busy, done, fire_cnt
    );
endinterface

// File: rtl/pulsegen_seq.sv
// Fire sequencer: issues NCH-wide one-cycle triggers at a fixed period or on
// external trigger edges, with run parameters shadowed at start.
module pulsegen_seq #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input logic           clk,
    input logic           rst,
    pulsegen_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_TRIG, FIRE, HOLD} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     period_q, period_d;
    logic [WIDTH-1:0]     repeat_q, repeat_d;
    logic [WIDTH-1:0]     hold_q, hold_d;
    logic [WIDTH-1:0]     fire_cnt_q, fire_cnt_d;
    logic                 ext_en_q, ext_en_d;
    logic [NCH-1:0]       ch_en_q, ch_en_d;
    logic [NCH*WIDTH-1:0] delay_q, delay_d;
    logic [NCH*WIDTH-1:0] pulse_q, pulse_d;
    logic [NCH-1:0]       ch_trig_q, ch_trig_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 trig_q;
    logic [WIDTH-1:0]     p_eff;
    logic                 rise;

    // Periods below 2 would leave no room for HOLD, so they run as 2.
    assign p_eff = (period_q < WIDTH'(2)) ? WIDTH'(2) : period_q;
    assign rise  = bus.ext_trig & ~trig_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch.
        state_d    = state_q;
        period_d   = period_q;
        repeat_d   = repeat_q;
        hold_d     = hold_q;
        fire_cnt_d = fire_cnt_q;
        ext_en_d   = ext_en_q;
        ch_en_d    = ch_en_q;
        delay_d    = delay_q;
        pulse_d    = pulse_q;
        ch_trig_d  = '0;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    period_d   = bus.period;
                    repeat_d   = bus.repeat_n;
                    ext_en_d   = bus.ext_trig_en;
                    ch_en_d    = bus.ch_en;
                    delay_d    = bus.cfg_delay;
                    pulse_d    = bus.cfg_pulse;
                    fire_cnt_d = '0;
                    state_d    = bus.ext_trig_en ? WAIT_TRIG : FIRE;
                end
            end
            WAIT_TRIG: begin
                if (rise) state_d = FIRE;
            end
            FIRE: begin
                state_d = HOLD;
                hold_d  = p_eff - WIDTH'(2);
            end
            HOLD: begin
                if (hold_q == '0) begin
                    if (repeat_q != '0 && fire_cnt_q == repeat_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ext_en_q ? WAIT_TRIG : FIRE;
                    end
                end else begin
                    hold_d = hold_q - WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.stop) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        // Outputs are registered, so they are derived from the next state.
        if (state_d == FIRE) begin
            fire_cnt_d = fire_cnt_d + WIDTH'(1);
            ch_trig_d  = ch_en_d;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= IDLE;
            period_q   <= '0;
            repeat_q   <= '0;
            hold_q     <= '0;
            fire_cnt_q <= '0;
            ext_en_q   <= 1'b0;
            ch_en_q    <= '0;
            delay_q    <= '0;
            pulse_q    <= '0;
            ch_trig_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            repeat_q   <= repeat_d;
            hold_q     <= hold_d;
            fire_cnt_q <= fire_cnt_d;
            ext_en_q   <= ext_en_d;
            ch_en_q    <= ch_en_d;
            delay_q    <= delay_d;
            pulse_q    <= pulse_d;
            ch_trig_q  <= ch_trig_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            trig_q     <= bus.ext_trig;
        end
    end

    assign bus.ch_trig   = ch_trig_q;
    assign bus.ch_tdelay = delay_q;
    assign bus.ch_tpulse = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fire_cnt  = fire_cnt_q;
endmodule

// File: tb/tb_pulsegen_seq.sv
// Self-checking bench for pulsegen_seq: directed vector table, hand-written
// corner sequences and a randomized run against a schedule-based model.
module tb_pulsegen_seq;
    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pulsegen_seq_if #(.WIDTH(W), .NCH(N)) bus ();
    pulsegen_seq #(.WIDTH(W), .NCH(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         start;
        logic         stop;
        logic [W-1:0] period;
        logic [W-1:0] rep;
        logic [N-1:0] ch_en;
        logic [N-1:0] exp_trig;
        logic         exp_busy;
        logic         exp_done;
        logic [W-1:0] exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] trig, input logic busy,
                           input logic done, input logic [W-1:0] cnt);
        check({tag, ".ch_trig"}, 64'(bus.ch_trig), 64'(trig));
        check({tag, ".busy"}, 64'(bus.busy), 64'(busy));
        check({tag, ".done"}, 64'(bus.done), 64'(done));
        check({tag, ".fire_cnt"}, 64'(bus.fire_cnt), 64'(cnt));
    endtask

    // Reference model: tracks the run as a schedule of absolute cycle numbers.
    bit           m_run, m_ext, m_prev;
    int           m_next_fire, m_arm_at, m_finish_at, m_p;
    logic [W-1:0] m_rep, m_cnt;
    logic [N-1:0] m_chen, e_trig;
    logic [63:0]  m_delay, m_pulse;
    logic         e_done;

    // Given the inputs of cycle c, predicts outputs visible in cycle c+1.
    task automatic model_cycle(input int c);
        bit r;
        r = bus.ext_trig && !m_prev;
        e_trig = '0;
        e_done = 1'b0;
        if (rst) begin
            m_run = 0; m_ext = 0; m_prev = 0; m_cnt = '0; m_rep = '0;
            m_chen = '0; m_delay = '0; m_pulse = '0;
            m_next_fire = -1; m_finish_at = -1; m_arm_at = 0; m_p = 2;
            return;
        end
        if (bus.stop) begin
            m_run = 0;
        end else if (!m_run) begin
            if (bus.start) begin
                m_run = 1;
                m_p = (bus.period < 2) ? 2 : int'(bus.period);
                m_rep = bus.repeat_n; m_chen = bus.ch_en; m_ext = bus.ext_trig_en;
                m_delay = bus.cfg_delay; m_pulse = bus.cfg_pulse;
                m_cnt = '0; m_finish_at = -1;
                if (m_ext) begin m_next_fire = -1; m_arm_at = c + 1; end
                else m_next_fire = c + 1;
            end
        end else if (m_ext && m_next_fire < 0 && m_finish_at < 0 && c >= m_arm_at && r) begin
            m_next_fire = c + 1;
        end
        if (m_run && m_next_fire == c + 1) begin
            e_trig = m_chen;
            m_cnt = m_cnt + 1'b1;
            if (m_rep != 0 && m_cnt == m_rep) begin
                m_finish_at = c + 1 + m_p; m_next_fire = -1;
            end else if (!m_ext) begin
                m_next_fire = c + 1 + m_p;
            end else begin
                m_next_fire = -1; m_arm_at = c + 1 + m_p;
            end
        end
        if (m_run && m_finish_at == c + 1) begin
            m_run = 0; e_done = 1'b1;
        end
        m_prev = bus.ext_trig;
    endtask

    initial begin
        vec_t vecs[11];
        logic [63:0] dly0;

        bus.start = 0; bus.stop = 0; bus.period = '0; bus.repeat_n = '0;
        bus.ext_trig_en = 0; bus.ext_trig = 0; bus.ch_en = '0;
        bus.cfg_delay = '0; bus.cfg_pulse = '0;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk_out("reset", '0, 0, 0, '0);
        check("reset.ch_tdelay", bus.ch_tdelay, '0);
        check("reset.ch_tpulse", bus.ch_tpulse, '0);

        // Clamped period, start+stop ignored, period=1 single fire.
        vecs[0]  = '{1, 0, 0, 2, 4'b1111, 4'b1111, 1, 0, 1};
        vecs[1]  = '{0, 0, 0, 2, 4'b1111, 4'b0000, 1, 0, 1};
        vecs[2]  = '{0, 0, 0, 2, 4'b1111, 4'b1111, 1, 0, 2};
        vecs[3]  = '{0, 0, 0, 2, 4'b1111, 4'b0000, 1, 0, 2};
        vecs[4]  = '{0, 0, 0, 2, 4'b1111, 4'b0000, 0, 1, 2};
        vecs[5]  = '{0, 0, 0, 2, 4'b1111, 4'b0000, 0, 0, 2};
        vecs[6]  = '{1, 1, 0, 2, 4'b1111, 4'b0000, 0, 0, 2};
        vecs[7]  = '{0, 0, 0, 2, 4'b1111, 4'b0000, 0, 0, 2};
        vecs[8]  = '{1, 0, 1, 1, 4'b0010, 4'b0010, 1, 0, 1};
        vecs[9]  = '{0, 0, 1, 1, 4'b0010, 4'b0000, 1, 0, 1};
        vecs[10] = '{0, 0, 1, 1, 4'b0010, 4'b0000, 0, 1, 1};
        for (int i = 0; i < 11; i++) begin
            bus.start = vecs[i].start; bus.stop = vecs[i].stop;
            bus.period = vecs[i].period; bus.repeat_n = vecs[i].rep; bus.ch_en = vecs[i].ch_en;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_trig, vecs[i].exp_busy,
                    vecs[i].exp_done, vecs[i].exp_cnt);
        end
        bus.start = 0; bus.stop = 0;
        tick();

        // Internal period 5, three fires; mid-run config changes must not leak.
        dly0 = 64'h0004_0003_0002_0001;
        bus.period = 5; bus.repeat_n = 3; bus.ch_en = 4'b0101;
        bus.cfg_delay = dly0; bus.cfg_pulse = 64'h0040_0030_0020_0010;
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 1; k <= 17; k++) begin
            chk_out($sformatf("int.k%0d", k), (k == 1 || k == 6 || k == 11) ? 4'b0101 : 4'b0000,
                    k < 16, k == 16, (k >= 11) ? 16'd3 : (k >= 6) ? 16'd2 : 16'd1);
            check($sformatf("int.k%0d.ch_tdelay", k), bus.ch_tdelay, dly0);
            if (k == 3) begin
                bus.cfg_delay = 64'h0000_1111_2222_3333;
                bus.ch_en = 4'b1110;
            end
            tick();
        end
        bus.start = 1;
        tick();
        bus.start = 0;
        check("reshadow.ch_tdelay", bus.ch_tdelay, 64'h0000_1111_2222_3333);
        check("reshadow.ch_trig", 64'(bus.ch_trig), 64'(4'b1110));
        bus.stop = 1;
        tick();
        bus.stop = 0;

        // External trigger: level high before start, edge in HOLD ignored.
        bus.ext_trig_en = 1; bus.period = 4; bus.repeat_n = 2; bus.ch_en = 4'b1010;
        bus.ext_trig = 1; bus.start = 1;
        tick();
        bus.start = 0;
        chk_out("ext.pre1", '0, 1, 0, '0);
        tick();
        bus.ext_trig = 0;
        chk_out("ext.pre2", '0, 1, 0, '0);
        tick();
        for (int j = 0; j <= 16; j++) begin
            bus.ext_trig = (j == 0 || j == 2 || j == 10);
            chk_out($sformatf("ext.j%0d", j), (j == 1 || j == 11) ? 4'b1010 : 4'b0000,
                    j < 15, j == 15, (j >= 11) ? 16'd2 : (j >= 1) ? 16'd1 : 16'd0);
            tick();
        end
        bus.ext_trig_en = 0; bus.ext_trig = 0;

        // Continuous run aborted after the fourth fire, then start+stop ignored.
        bus.period = 3; bus.repeat_n = 0; bus.ch_en = 4'b0011; bus.start = 1;
        tick();
        bus.start = 0;
        for (int k = 1; k <= 11; k++) begin
            chk_out($sformatf("abort.k%0d", k), (k % 3 == 1) ? 4'b0011 : 4'b0000,
                    1, 0, 16'((k + 2) / 3));
            if (k == 11) bus.stop = 1;
            tick();
        end
        chk_out("abort.stopped", '0, 0, 0, 4);
        bus.start = 1;
        tick();
        chk_out("abort.start_with_stop", '0, 0, 0, 4);
        bus.start = 0; bus.stop = 0;
        tick();
        chk_out("abort.idle", '0, 0, 0, 4);

        // Reset in the middle of HOLD.
        bus.period = 5; bus.ch_en = 4'b1111; bus.start = 1;
        tick();
        bus.start = 0;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        chk_out("rst_hold", '0, 0, 0, '0);
        check("rst_hold.ch_tdelay", bus.ch_tdelay, '0);
        check("rst_hold.ch_tpulse", bus.ch_tpulse, '0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rst_hold.after%0d.ch_trig", k), 64'(bus.ch_trig), 64'd0);
            check($sformatf("rst_hold.after%0d.busy", k), 64'(bus.busy), 64'd0);
        end

        // Randomized run against the schedule model.
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 0) || ($urandom_range(0, 499) == 0);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.stop = ($urandom_range(0, 39) == 0);
            bus.period = W'($urandom_range(0, 6));
            bus.repeat_n = W'($urandom_range(0, 4));
            bus.ext_trig_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.ext_trig = ~bus.ext_trig;
            bus.ch_en = N'($urandom_range(0, 15));
            bus.cfg_delay = {$urandom, $urandom};
            bus.cfg_pulse = {$urandom, $urandom};
            model_cycle(c);
            tick();
            chk_out($sformatf("rnd.c%0d", c), e_trig, m_run, e_done, m_cnt);
            check($sformatf("rnd.c%0d.ch_tdelay", c), bus.ch_tdelay, m_delay);
            check($sformatf("rnd.c%0d.ch_tpulse", c), bus.ch_tpulse, m_pulse);
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
